// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller and its neighbours.
// Holds the controller state encoding, coin values and the default beverage
// prices. The beverage dispenser reuses the same price constants.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } vend_state_e;

  localparam int COIN_QUARTER = 25;
  localparam int COIN_DIME    = 10;
  localparam int COIN_NICKEL  = 5;

  localparam int DEF_PRICE1 = 75;
  localparam int DEF_PRICE2 = 100;
  localparam int DEF_PRICE3 = 125;
  localparam int DEF_PRICE4 = 150;

  // Total value of the coins presented in one cycle (at most 40 cents).
  function automatic logic [5:0] coinSum(input logic q, input logic d, input logic n);
    coinSum = (q ? 6'(COIN_QUARTER) : 6'd0)
            + (d ? 6'(COIN_DIME)    : 6'd0)
            + (n ? 6'(COIN_NICKEL)  : 6'd0);
  endfunction

endpackage

// File: rtl/vend_price_sel.sv
// Combinational select arbiter and price check for the vending controller.
// The lowest-numbered pressed button wins. Its price is muxed out and
// compared against the current credit.
module vend_price_sel
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 10,
  parameter int PRICE1   = DEF_PRICE1,
  parameter int PRICE2   = DEF_PRICE2,
  parameter int PRICE3   = DEF_PRICE3,
  parameter int PRICE4   = DEF_PRICE4
) (
  input  logic [3:0]          i_sel,
  input  logic [CREDIT_W-1:0] i_credit,
  output logic                o_anySel,
  output logic [3:0]          o_grant,
  output logic [CREDIT_W-1:0] o_price,
  output logic                o_enough
);

  assign o_anySel = |i_sel;
  assign o_grant  = i_sel & (~i_sel + 4'd1);

  // Price of the granted beverage; zero when nothing is pressed.
  always_comb begin
    o_price = '0;
    case (o_grant)
      4'b0001: o_price = CREDIT_W'(PRICE1);
      4'b0010: o_price = CREDIT_W'(PRICE2);
      4'b0100: o_price = CREDIT_W'(PRICE3);
      4'b1000: o_price = CREDIT_W'(PRICE4);
      default: o_price = '0;
    endcase
  end

  assign o_enough = o_anySel && (i_credit >= o_price);

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit accumulation, beverage select,
// dispense strobe and change/refund handshake with the coin dispenser.
// Optional build macro VEND_TIMEOUT_EN adds an inactivity auto-refund after
// TIMEOUT_CYC idle cycles in CREDIT; without it credit is held indefinitely.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 10,
  parameter int MAX_CREDIT  = 500,
  parameter int PRICE1      = DEF_PRICE1,
  parameter int PRICE2      = DEF_PRICE2,
  parameter int PRICE3      = DEF_PRICE3,
  parameter int PRICE4      = DEF_PRICE4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_quarter,
  input  logic                in_dime,
  input  logic                in_nickel,
  input  logic [3:0]          sel,
  input  logic                cancel,
  input  logic                chg_done,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          vend,
  output logic                chg_req,
  output logic [CREDIT_W-1:0] chg_amt,
  output logic                coin_reject,
  output logic                short_funds,
  output logic                busy
);

  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_chkMaxCredit
    $error("vend_sequencer: MAX_CREDIT must be below 2**CREDIT_W");
  end

  if (TIMEOUT_CYC < 1) begin : g_chkTimeout
    $error("vend_sequencer: TIMEOUT_CYC must be at least 1");
  end

  vend_state_e         r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] r_price;
  logic [3:0]          r_vend;
  logic                r_chgReq;
  logic [CREDIT_W-1:0] r_chgAmt;
  logic                r_coinReject;
  logic                r_shortFunds;
  logic                r_busy;

  logic [5:0]          w_coin;
  logic                w_coinSeen;
  logic [CREDIT_W:0]   w_total;
  logic                w_fits;
  logic [CREDIT_W-1:0] w_nextCredit;
  logic                w_coinRefused;
  logic [CREDIT_W-1:0] w_remain;
  logic                w_anySel;
  logic [3:0]          w_grant;
  logic [CREDIT_W-1:0] w_price;
  logic                w_enough;
  logic                w_timeout;
  logic                w_cancel;

  // One extra bit on the sum so an over-limit total cannot wrap past the check.
  assign w_coin        = coinSum(in_quarter, in_dime, in_nickel);
  assign w_coinSeen    = in_quarter | in_dime | in_nickel;
  assign w_total       = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin);
  assign w_fits        = (w_total <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_nextCredit  = w_fits ? w_total[CREDIT_W-1:0] : r_credit;
  assign w_coinRefused = w_coinSeen & ~w_fits;
  assign w_remain      = r_credit - r_price;
  assign w_cancel      = cancel | w_timeout;

  vend_price_sel #(
    .CREDIT_W (CREDIT_W),
    .PRICE1   (PRICE1),
    .PRICE2   (PRICE2),
    .PRICE3   (PRICE3),
    .PRICE4   (PRICE4)
  ) u_priceSel (
    .i_sel    (sel),
    .i_credit (r_credit),
    .o_anySel (w_anySel),
    .o_grant  (w_grant),
    .o_price  (w_price),
    .o_enough (w_enough)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_idleCnt;

  // Count idle cycles in CREDIT; any coin or button press restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idleCnt <= '0;
    end else if ((r_state != CREDIT) || w_coinSeen || (|sel)) begin
      r_idleCnt <= '0;
    end else if (!w_timeout) begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == CREDIT) && (r_idleCnt == TO_W'(TIMEOUT_CYC));
`else
  assign w_timeout = 1'b0;
`endif

  // Transaction FSM with credit register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_credit     <= '0;
      r_price      <= '0;
      r_vend       <= '0;
      r_chgReq     <= 1'b0;
      r_chgAmt     <= '0;
      r_coinReject <= 1'b0;
      r_shortFunds <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_vend       <= '0;
      r_coinReject <= 1'b0;
      r_shortFunds <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_coinSeen) begin
            if (w_fits) begin
              r_credit <= w_total[CREDIT_W-1:0];
              r_state  <= CREDIT;
            end else begin
              r_coinReject <= 1'b1;
            end
          end
        end
        CREDIT: begin
          if (w_cancel) begin
            r_credit     <= w_nextCredit;
            r_chgAmt     <= w_nextCredit;
            r_chgReq     <= 1'b1;
            r_busy       <= 1'b1;
            r_coinReject <= w_coinRefused;
            r_state      <= CHANGE;
          end else if (w_enough) begin
            r_vend       <= w_grant;
            r_price      <= w_price;
            r_busy       <= 1'b1;
            r_coinReject <= w_coinSeen;
            r_state      <= VEND;
          end else begin
            r_credit     <= w_nextCredit;
            r_coinReject <= w_coinRefused;
            r_shortFunds <= w_anySel;
          end
        end
        VEND: begin
          r_coinReject <= w_coinSeen;
          r_credit     <= w_remain;
          if (w_remain != '0) begin
            r_chgReq <= 1'b1;
            r_chgAmt <= w_remain;
            r_state  <= CHANGE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CHANGE: begin
          r_coinReject <= w_coinSeen;
          if (chg_done) begin
            r_chgReq <= 1'b0;
            r_chgAmt <= '0;
            r_credit <= '0;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign credit      = r_credit;
  assign vend        = r_vend;
  assign chg_req     = r_chgReq;
  assign chg_amt     = r_chgAmt;
  assign coin_reject = r_coinReject;
  assign short_funds = r_shortFunds;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios followed by
// random front-panel traffic, checked every cycle against a transaction-level
// model of credit, pending dispense and owed change.
module tb_vend_sequencer;

  localparam int CREDIT_W = 10;
  localparam int MAX_CRED = 500;

  logic                clk;
  logic                rst;
  logic                in_quarter;
  logic                in_dime;
  logic                in_nickel;
  logic [3:0]          sel;
  logic                cancel;
  logic                chg_done;
  logic [CREDIT_W-1:0] credit;
  logic [3:0]          vend;
  logic                chg_req;
  logic [CREDIT_W-1:0] chg_amt;
  logic                coin_reject;
  logic                short_funds;
  logic                busy;

  int unsigned nCompared;
  int unsigned nMismatched;

  int         priceTab [4] = '{75, 100, 125, 150};
  int         mCredit;
  logic [3:0] mVend;
  int         mVendPrice;
  bit         mReq;
  bit         eRej;
  bit         eShort;

  vend_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .in_quarter  (in_quarter),
    .in_dime     (in_dime),
    .in_nickel   (in_nickel),
    .sel         (sel),
    .cancel      (cancel),
    .chg_done    (chg_done),
    .credit      (credit),
    .vend        (vend),
    .chg_req     (chg_req),
    .chg_amt     (chg_amt),
    .coin_reject (coin_reject),
    .short_funds (short_funds),
    .busy        (busy)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("credit", 32'(credit), 32'(mCredit));
    checkOne("vend", 32'(vend), 32'(mVend));
    checkOne("chg_req", 32'(chg_req), 32'(mReq));
    if (mReq) checkOne("chg_amt", 32'(chg_amt), 32'(mCredit));
    checkOne("coin_reject", 32'(coin_reject), 32'(eRej));
    checkOne("short_funds", 32'(short_funds), 32'(eShort));
    checkOne("busy", 32'(busy), 32'((mVend != 4'd0) || mReq));
  endtask

  task automatic modelReset();
    mCredit    = 0;
    mVend      = 4'd0;
    mVendPrice = 0;
    mReq       = 1'b0;
    eRej       = 1'b0;
    eShort     = 1'b0;
  endtask

  // Advance the model by one clock given the inputs presented in that cycle.
  task automatic modelStep(input logic q, input logic d, input logic n,
                           input logic [3:0] s, input logic c, input logic done);
    int coins;
    int idx;
    bit fits;
    coins  = 25 * int'(q) + 10 * int'(d) + 5 * int'(n);
    fits   = (mCredit + coins) <= MAX_CRED;
    eRej   = 1'b0;
    eShort = 1'b0;
    if (mVend != 4'd0) begin
      eRej    = (coins > 0);
      mCredit = mCredit - mVendPrice;
      mVend   = 4'd0;
      mReq    = (mCredit > 0);
    end else if (mReq) begin
      eRej = (coins > 0);
      if (done) begin
        mReq    = 1'b0;
        mCredit = 0;
      end
    end else begin
      idx = -1;
      for (int i = 3; i >= 0; i--) if (s[i]) idx = i;
      if (mCredit > 0 && c) begin
        if (coins > 0 && fits) mCredit += coins;
        else if (coins > 0)    eRej = 1'b1;
        mReq = 1'b1;
      end else if (mCredit > 0 && idx >= 0 && mCredit >= priceTab[idx]) begin
        mVend      = 4'(1 << idx);
        mVendPrice = priceTab[idx];
        eRej       = (coins > 0);
      end else begin
        if (mCredit > 0 && idx >= 0) eShort = 1'b1;
        if (coins > 0 && fits) mCredit += coins;
        else if (coins > 0)    eRej = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic q, input logic d, input logic n,
                               input logic [3:0] s, input logic c, input logic done);
    @(negedge clk);
    in_quarter = q;
    in_dime    = d;
    in_nickel  = n;
    sel        = s;
    cancel     = c;
    chg_done   = done;
    modelStep(q, d, n, s, c, done);
    @(posedge clk);
    #1;
    checkOutput();
    in_quarter = 1'b0;
    in_dime    = 1'b0;
    in_nickel  = 1'b0;
    sel        = 4'd0;
    cancel     = 1'b0;
    chg_done   = 1'b0;
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  // Assert reset between clock edges so only the asynchronous path can clear outputs.
  task automatic asyncReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst         = 1'b1;
    in_quarter  = 1'b0;
    in_dime     = 1'b0;
    in_nickel   = 1'b0;
    sel         = 4'd0;
    cancel      = 1'b0;
    chg_done    = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput();
    rst = 1'b0;

    $display("[TB] idle inputs: select, cancel and done ignored");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1);

    $display("[TB] exact-price vend of beverage 1");
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
    idleCycles(3);

    $display("[TB] short funds then vend with change");
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    idleCycles(1);

    $display("[TB] credit ceiling");
    repeat (19) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    $display("[TB] simultaneous coins, refund, reset mid-change");
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    idleCycles(1);
    asyncReset();
    idleCycles(3);

    $display("[TB] cancel beats select, coin refused during change");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    $display("[TB] coin with cancel and coin with select");
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      logic       q;
      logic       d;
      logic       n;
      logic [3:0] s;
      logic       c;
      logic       dn;
      q  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 3) == 0);
      n  = ($urandom_range(0, 3) == 0);
      s  = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      c  = ($urandom_range(0, 24) == 0);
      dn = mReq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      applyStimulus(q, d, n, s, c, dn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
